alu_issue: RTL and testbench

- Issue-side transmitter for the ALU reservation station.
- Accepts decoded ALU-class instructions from the decoder over a valid/ready handshake and buffers them in a small FIFO.
- Allocates a ROB entry tag per instruction and drives the RS instruction-input interface (from_rob pulse plus fields).
- Tracks RS occupancy with credits returned by the RS execute pulse, so it never overruns the RS and does not rely on the lagged rs_full.

---
 rtl/alu_issue_pkg.sv | 27 ++
 rtl/alu_issue_fifo.sv | 55 +++++
 rtl/alu_issue.sv | 132 +++++++++++++
 tb/tb_alu_issue.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue path: opcode classes,
// tag sizing and the payload carried from decoder to the RS.
package alu_issue_pkg;

    localparam int TAG_W = 5;
    localparam logic [TAG_W-1:0] NO_TAG = '0;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic [10:0] opcode;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } issue_pkt_t;

    localparam int PKT_W = $bits(issue_pkt_t);

    function automatic logic is_alu_op(input logic [6:0] op);
        return op inside {OPC_LUI, OPC_AUIPC, OPC_OP_IMM, OPC_OP};
    endfunction

endpackage

// File: rtl/alu_issue_fifo.sv
// Decoder-side circular buffer; pointers carry one extra wrap bit
// so full and empty are distinguishable without a counter.
module issue_fifo
    import alu_issue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    input  logic       push,
    input  logic       pop,
    input  issue_pkt_t din,
    output issue_pkt_t dout,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    issue_pkt_t mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    // A push into a full buffer is legal only alongside a pop.
    assign do_push = en && !clr && push && (!full || pop);
    assign do_pop  = en && !clr && pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (en && clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/alu_issue.sv
// ALU issue transmitter: buffers decoded ops, allocates ROB tags and
// drives the RS input while tracking RS and ROB occupancy locally.
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int RS_SIZE    = 10,
    parameter int ROB_SIZE   = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             flush,
    input  logic             dec_valid,
    output logic             dec_ready,
    input  logic [10:0]      dec_opcode,
    input  logic [31:0]      dec_pc,
    input  logic [4:0]       dec_rs1,
    input  logic [4:0]       dec_rs2,
    input  logic [31:0]      dec_imm,
    input  logic             rs_exec,
    input  logic             rob_commit,
    output logic             to_rs_valid,
    output logic [TAG_W-1:0] to_rs_entry,
    output logic [10:0]      to_rs_opcode,
    output logic [31:0]      to_rs_pc,
    output logic [4:0]       to_rs_rs1,
    output logic [4:0]       to_rs_rs2,
    output logic [31:0]      to_rs_imm,
    output logic             bad_op
);

    localparam int CW = $clog2(RS_SIZE + 1);
    localparam int IW = $clog2(ROB_SIZE + 1);
    localparam logic [CW-1:0]    CRED_MAX  = CW'(RS_SIZE);
    localparam logic [IW-1:0]    INFL_MAX  = IW'(ROB_SIZE);
    localparam logic [TAG_W-1:0] TAG_MAX   = TAG_W'(ROB_SIZE);
    localparam logic [TAG_W-1:0] TAG_FIRST = TAG_W'(1);

    logic [CW-1:0]    credits;
    logic [IW-1:0]    inflight;
    logic [TAG_W-1:0] next_tag;

    logic       full;
    logic       empty;
    logic       issue;
    logic       alu_op;
    logic       take;
    logic       push;
    logic       bad_offer;
    logic       exec_ok;
    logic       commit_ok;
    issue_pkt_t din;
    issue_pkt_t head;

    assign din = '{
        opcode: dec_opcode,
        pc:     dec_pc,
        rs1:    dec_rs1,
        rs2:    dec_rs2,
        imm:    dec_imm
    };

    assign alu_op = is_alu_op(dec_opcode[6:0]);

    assign issue = rdy_in && !flush && !empty &&
                   (credits != '0) && (inflight < INFL_MAX);

    // Never looks at dec_valid, so the decoder may wait on it freely.
    assign dec_ready = rdy_in && (!full || issue);

    assign take      = rdy_in && !flush && dec_valid && dec_ready;
    assign push      = take && alu_op;
    assign bad_offer = take && !alu_op;

    assign exec_ok   = rs_exec && (credits < CRED_MAX);
    assign commit_ok = rob_commit && (inflight != '0);

    issue_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_in),
        .rst   (rst_in),
        .en    (rdy_in),
        .clr   (flush),
        .push  (push),
        .pop   (issue),
        .din   (din),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            credits      <= CRED_MAX;
            inflight     <= '0;
            next_tag     <= TAG_FIRST;
            to_rs_valid  <= 1'b0;
            to_rs_entry  <= NO_TAG;
            to_rs_opcode <= '0;
            to_rs_pc     <= '0;
            to_rs_rs1    <= '0;
            to_rs_rs2    <= '0;
            to_rs_imm    <= '0;
            bad_op       <= 1'b0;
        end else if (!rdy_in) begin
            to_rs_valid <= 1'b0;
        end else if (flush) begin
            credits     <= CRED_MAX;
            inflight    <= '0;
            next_tag    <= TAG_FIRST;
            to_rs_valid <= 1'b0;
        end else begin
            to_rs_valid <= issue;
            credits     <= credits - CW'(issue) + CW'(exec_ok);
            inflight    <= inflight + IW'(issue) - IW'(commit_ok);
            if (issue) begin
                next_tag     <= (next_tag == TAG_MAX) ?
                                TAG_FIRST : next_tag + TAG_FIRST;
                to_rs_entry  <= next_tag;
                to_rs_opcode <= head.opcode;
                to_rs_pc     <= head.pc;
                to_rs_rs1    <= head.rs1;
                to_rs_rs2    <= head.rs2;
                to_rs_imm    <= head.imm;
            end
            if (bad_offer) bad_op <= 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Randomised scoreboard bench for alu_issue against a
// transaction-level model of queue, credits and tags.
module tb_alu_issue;

    localparam int RS  = 10;
    localparam int ROB = 16;
    localparam int FD  = 4;

    logic        clk = 1'b1;
    logic        rst_in;
    logic        rdy_in;
    logic        flush;
    logic        dec_valid;
    logic        dec_ready;
    logic [10:0] dec_opcode;
    logic [31:0] dec_pc;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [31:0] dec_imm;
    logic        rs_exec;
    logic        rob_commit;
    logic        to_rs_valid;
    logic [4:0]  to_rs_entry;
    logic [10:0] to_rs_opcode;
    logic [31:0] to_rs_pc;
    logic [4:0]  to_rs_rs1;
    logic [4:0]  to_rs_rs2;
    logic [31:0] to_rs_imm;
    logic        bad_op;

    always #5 clk = ~clk;

    alu_issue dut (
        .clk_in       (clk),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .flush        (flush),
        .dec_valid    (dec_valid),
        .dec_ready    (dec_ready),
        .dec_opcode   (dec_opcode),
        .dec_pc       (dec_pc),
        .dec_rs1      (dec_rs1),
        .dec_rs2      (dec_rs2),
        .dec_imm      (dec_imm),
        .rs_exec      (rs_exec),
        .rob_commit   (rob_commit),
        .to_rs_valid  (to_rs_valid),
        .to_rs_entry  (to_rs_entry),
        .to_rs_opcode (to_rs_opcode),
        .to_rs_pc     (to_rs_pc),
        .to_rs_rs1    (to_rs_rs1),
        .to_rs_rs2    (to_rs_rs2),
        .to_rs_imm    (to_rs_imm),
        .bad_op       (bad_op)
    );

    typedef struct {
        int          stamp;
        logic [4:0]  tag;
        logic [10:0] op;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } item_t;

    item_t pend_q[$];
    item_t exp_q[$];
    int    m_cred;
    int    m_infl;
    int    m_tag;
    bit    m_bad;
    bit    m_issue;
    bit    m_ready;
    int    pcount = 0;
    bit    armed  = 0;
    bit    rst_req;
    int    checks = 0;
    int    passes = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at t=%0t",
                     name, act, exp, $time);
        else
            passes++;
    endtask

    function automatic bit alu_class(logic [6:0] op);
        return op == 7'b0110111 || op == 7'b0010111 ||
               op == 7'b0010011 || op == 7'b0110011;
    endfunction

    task automatic drive(bit v, logic [6:0] op7, bit ex, bit cm,
                         bit fl, bit rd, bit fix = 1'b0);
        item_t it;
        int c0;
        int i0;
        @(negedge clk);
        rst_in     = rst_req;
        dec_valid  = v;
        dec_opcode = {4'($urandom), op7};
        dec_pc     = $urandom;
        dec_rs1    = fix ? 5'd3 : 5'($urandom);
        dec_rs2    = 5'($urandom);
        dec_imm    = fix ? 32'd5 : $urandom;
        rs_exec    = ex;
        rob_commit = cm;
        flush      = fl;
        rdy_in     = rd;
        #1;
        m_issue = rd && !fl && pend_q.size() > 0 &&
                  m_cred > 0 && m_infl < ROB;
        m_ready = rd && (pend_q.size() < FD || m_issue);
        if (!rst_in) chk("dec_ready", dec_ready, m_ready);
        @(posedge clk);
        pcount++;
        if (rst_in) begin
            pend_q.delete();
            m_cred = RS;
            m_infl = 0;
            m_tag  = 1;
            m_bad  = 0;
        end else if (rd) begin
            if (fl) begin
                pend_q.delete();
                m_cred = RS;
                m_infl = 0;
                m_tag  = 1;
            end else begin
                c0 = m_cred;
                i0 = m_infl;
                if (m_issue) begin
                    it = pend_q.pop_front();
                    it.stamp = pcount;
                    it.tag   = 5'(m_tag);
                    exp_q.push_back(it);
                    m_tag = (m_tag == ROB) ? 1 : m_tag + 1;
                end
                m_cred = c0 - int'(m_issue) + ((ex && c0 < RS) ? 1 : 0);
                m_infl = i0 + int'(m_issue) - ((cm && i0 > 0) ? 1 : 0);
                if (v && m_ready) begin
                    if (alu_class(op7)) begin
                        it.stamp = 0;
                        it.tag   = '0;
                        it.op    = dec_opcode;
                        it.pc    = dec_pc;
                        it.rs1   = dec_rs1;
                        it.rs2   = dec_rs2;
                        it.imm   = dec_imm;
                        pend_q.push_back(it);
                    end else begin
                        m_bad = 1;
                    end
                end
            end
        end
    endtask

    task automatic idle(int n, bit ex = 0, bit cm = 0);
        for (int i = 0; i < n; i++) drive(0, 7'b0110011, ex, cm, 0, 1);
    endtask

    always @(negedge clk) begin
        item_t e;
        if (armed) begin
            chk("bad_op", bad_op, m_bad);
            if (to_rs_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_pulse", to_rs_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk("issue_cycle", 64'(pcount), 64'(e.stamp));
                    chk("entry", to_rs_entry, e.tag);
                    chk("opcode", to_rs_opcode, e.op);
                    chk("pc", to_rs_pc, e.pc);
                    chk("rs1", to_rs_rs1, e.rs1);
                    chk("rs2", to_rs_rs2, e.rs2);
                    chk("imm", to_rs_imm, e.imm);
                end
            end else if (exp_q.size() > 0 && exp_q[0].stamp <= pcount) begin
                e = exp_q.pop_front();
                chk("missed_pulse", to_rs_valid, 1'b1);
            end
        end
    end

    logic [6:0] ops [5];

    initial begin
        ops[0] = 7'b0110111;
        ops[1] = 7'b0010111;
        ops[2] = 7'b0010011;
        ops[3] = 7'b0110011;
        ops[4] = 7'b0100011;
        rst_in = 1; rdy_in = 1; flush = 0; dec_valid = 0;
        dec_opcode = '0; dec_pc = '0; dec_rs1 = '0; dec_rs2 = '0;
        dec_imm = '0; rs_exec = 0; rob_commit = 0;

        rst_req = 1;
        idle(2);
        #1;
        chk("rst_valid", to_rs_valid, 1'b0);
        chk("rst_entry", to_rs_entry, 5'd0);
        chk("rst_pc", to_rs_pc, 32'd0);
        chk("rst_imm", to_rs_imm, 32'd0);
        chk("rst_bad_op", bad_op, 1'b0);
        chk("rst_dec_ready", dec_ready, 1'b1);
        armed = 1;
        rst_req = 0;

        // single ADDI
        drive(1, 7'b0010011, 0, 0, 0, 1, 1);
        idle(3);

        // credit exhaustion, then one credit back
        for (int i = 0; i < 12; i++) drive(1, 7'b0110011, 0, 0, 0, 1);
        idle(4);
        drive(0, 7'b0110011, 1, 0, 0, 1);
        idle(3);
        drive(0, 7'b0110011, 0, 0, 1, 1);

        // tag exhaustion and wrap
        for (int i = 0; i < 20; i++)
            drive(1, ops[$urandom_range(0, 3)], 1, 0, 0, 1);
        idle(4, 1);
        drive(0, 7'b0110011, 1, 1, 0, 1);
        idle(3, 1);

        // non-ALU opcode
        drive(1, 7'b0100011, 1, 1, 0, 1);
        for (int i = 0; i < 4; i++) drive(1, 7'b0110011, 1, 1, 0, 1);
        idle(3, 1, 1);

        // flush with entries pending and an offer in flight
        drive(0, 7'b0110011, 0, 0, 1, 1);
        for (int i = 0; i < 8; i++) drive(1, 7'b0010011, 0, 0, 0, 1);
        drive(1, 7'b0010011, 0, 0, 1, 1);
        drive(1, 7'b0110111, 0, 0, 0, 1);
        idle(3);

        // frozen while rdy_in is low
        drive(0, 7'b0110011, 0, 0, 1, 1);
        for (int i = 0; i < 11; i++) drive(1, 7'b0110011, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) drive(1, 7'b0110011, 1, 1, 1, 0);
        drive(0, 7'b0110011, 1, 1, 0, 1);
        idle(4);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 9) < 7,
                  ops[($urandom_range(0, 49) == 0) ? 4 : $urandom_range(0, 3)],
                  $urandom_range(0, 9) < 4,
                  $urandom_range(0, 9) < 4,
                  $urandom_range(0, 99) < 3,
                  $urandom_range(0, 9) != 0);
        end

        idle(40, 1, 1);
        chk("drain", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
